// File: rtl/ddsm_pkg.sv
// Shared constants and helpers for the MASH delta-sigma modulator.
// Latency: n/a (package only).
// Backpressure: n/a.
package ddsm_pkg;

  // Width of the signed modulus-offset output word.
  localparam int DDSM_Y_W = 4;

  // Dither LFSR: 15-bit Fibonacci, polynomial x^15 + x^14 + 1.
  localparam int LFSR_W     = 15;
  localparam int LFSR_TAP_A = 14;  // x^15 term
  localparam int LFSR_TAP_B = 13;  // x^14 term
  localparam logic [LFSR_W-1:0] DDSM_LFSR_SEED = 15'h0001;

  typedef struct packed {
    logic signed [DDSM_Y_W-1:0] lo;
    logic signed [DDSM_Y_W-1:0] hi;
  } ddsm_range_t;

  // Legal output range for a given modulator order.
  function automatic ddsm_range_t ddsm_y_range(input int order);
    ddsm_range_t r;
    case (order)
      1:       begin r.lo = 4'sd0;  r.hi = 4'sd1; end
      2:       begin r.lo = -4'sd1; r.hi = 4'sd2; end
      default: begin r.lo = -4'sd3; r.hi = 4'sd4; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ddsm_accum_stage.sv
// One MASH accumulator stage: acc <= acc + addend + cin, carry out is the overflow.
// Latency: sum_lo/carry are combinational from acc and inputs; acc updates on en.
// Backpressure: none; en=0 holds the accumulator.
// Ports: clk, rst (sync, active-high), en, addend[FRAC_W], cin -> sum_lo[FRAC_W], carry.
module ddsm_accum_stage #(
  parameter int FRAC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [FRAC_W-1:0] addend,
  input  logic              cin,
  output logic [FRAC_W-1:0] sum_lo,
  output logic              carry
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  assign sum    = {1'b0, acc} + {1'b0, addend} + {{FRAC_W{1'b0}}, cin};
  assign sum_lo = sum[FRAC_W-1:0];
  assign carry  = sum[FRAC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum_lo;
    end
  end

endmodule

// File: rtl/mash_ddsm.sv
// MASH 1-1-1 delta-sigma modulator (order 1..3) with optional LFSR LSB dither.
// Latency: y is registered; an en edge presents the carries of the pre-edge state.
// Backpressure: none; en is the only flow control and en=0 holds all state.
// Ports: clk, rst (sync, active-high), en, load, frac_in[FRAC_W], dither_en
//        -> y (signed 4-bit offset), y_valid (delay line primed).
import ddsm_pkg::*;

module mash_ddsm #(
  parameter int                FRAC_W    = 16,
  parameter int                ORDER     = 3,
  parameter logic [LFSR_W-1:0] LFSR_SEED = DDSM_LFSR_SEED
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       load,
  input  logic [FRAC_W-1:0]          frac_in,
  input  logic                       dither_en,
  output logic signed [DDSM_Y_W-1:0] y,
  output logic                       y_valid
);

  localparam logic [1:0] PRIME_N = ORDER[1:0];

  function automatic logic [DDSM_Y_W-1:0] ext(input logic b);
    return {{(DDSM_Y_W-1){1'b0}}, b};
  endfunction

  logic [FRAC_W-1:0] frac_q;
  logic [LFSR_W-1:0] lfsr;
  logic [1:0]        prime_cnt;
  logic              stage1_cin;

  // chain[0] feeds stage 1; chain[i] is stage i's new low sum, feeding stage i+1
  // in the same cycle (no inter-stage register).
  logic [FRAC_W-1:0] chain [0:ORDER];
  logic [ORDER:1]    c;
  logic [DDSM_Y_W-1:0] y_next;
  logic              unused_sum_tail;

  assign chain[0]        = frac_q;
  assign stage1_cin      = dither_en & lfsr[0];
  assign unused_sum_tail = ^chain[ORDER];

  for (genvar i = 1; i <= ORDER; i++) begin : g_stage
    ddsm_accum_stage #(.FRAC_W(FRAC_W)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .addend (chain[i-1]),
      .cin    ((i == 1) ? stage1_cin : 1'b0),
      .sum_lo (chain[i]),
      .carry  (c[i])
    );
  end

  // Noise-cancellation network; modulo-16 arithmetic yields the signed result.
  if (ORDER == 1) begin : g_cancel1
    assign y_next = ext(c[1]);
  end else if (ORDER == 2) begin : g_cancel2
    logic c2_z1;
    always_ff @(posedge clk) begin
      if (rst)     c2_z1 <= 1'b0;
      else if (en) c2_z1 <= c[2];
    end
    assign y_next = ext(c[1]) + ext(c[2]) - ext(c2_z1);
  end else begin : g_cancel3
    logic c2_z1, c3_z1, c3_z2;
    always_ff @(posedge clk) begin
      if (rst) begin
        c2_z1 <= 1'b0;
        c3_z1 <= 1'b0;
        c3_z2 <= 1'b0;
      end else if (en) begin
        c2_z1 <= c[2];
        c3_z1 <= c[3];
        c3_z2 <= c3_z1;
      end
    end
    // c3 - 2*c3_z1 + c3_z2 is the second difference of the stage-3 carry.
    assign y_next = ext(c[1]) + ext(c[2]) - ext(c2_z1)
                  + ext(c[3]) - (ext(c3_z1) << 1) + ext(c3_z2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= '0;
      lfsr      <= LFSR_SEED;
      prime_cnt <= 2'd0;
    end else if (en) begin
      y    <= y_next;
      lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B]};
      if (prime_cnt != PRIME_N) prime_cnt <= prime_cnt + 2'd1;
    end
  end

  // load is independent of en; a concurrent en step still sums the old frac_q.
  always_ff @(posedge clk) begin
    if (rst)       frac_q <= '0;
    else if (load) frac_q <= frac_in;
  end

  assign y_valid = (prime_cnt == PRIME_N);

endmodule

// File: tb/tb_mash_ddsm.sv
// Directed bench for mash_ddsm: ORDER=1,2,3 instances driven in parallel.
module tb_mash_ddsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic        dither_en = 1'b0;
  logic [15:0] frac_in = 16'h0;

  logic signed [3:0] y1, y2, y3;
  logic              v1, v2, v3;

  int checks = 0;
  int errors = 0;

  mash_ddsm #(.FRAC_W(16), .ORDER(1)) u_o1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .frac_in(frac_in),
    .dither_en(dither_en), .y(y1), .y_valid(v1));
  mash_ddsm #(.FRAC_W(16), .ORDER(2)) u_o2 (
    .clk(clk), .rst(rst), .en(en), .load(load), .frac_in(frac_in),
    .dither_en(dither_en), .y(y2), .y_valid(v2));
  mash_ddsm #(.FRAC_W(16), .ORDER(3)) u_o3 (
    .clk(clk), .rst(rst), .en(en), .load(load), .frac_in(frac_in),
    .dither_en(dither_en), .y(y3), .y_valid(v3));

  // Reference model state (shared by all three orders: same inputs, same carries).
  int unsigned m_acc1, m_acc2, m_acc3;
  int          m_c2z1, m_c3z1, m_c3z2;
  int          m_y1, m_y2, m_y3, m_cnt;
  logic [14:0] m_lfsr;
  logic [15:0] m_frac;

  task automatic model_step();
    int unsigned s;
    int c1, c2, c3, cin;
    if (rst) begin
      m_acc1 = 0; m_acc2 = 0; m_acc3 = 0;
      m_c2z1 = 0; m_c3z1 = 0; m_c3z2 = 0;
      m_y1 = 0; m_y2 = 0; m_y3 = 0; m_cnt = 0;
      m_lfsr = 15'h0001; m_frac = 16'h0;
    end else begin
      if (en) begin
        cin = int'(dither_en & m_lfsr[0]);
        s = m_acc1 + m_frac + cin; c1 = int'(s >> 16); m_acc1 = s & 32'hFFFF;
        s = m_acc2 + m_acc1;       c2 = int'(s >> 16); m_acc2 = s & 32'hFFFF;
        s = m_acc3 + m_acc2;       c3 = int'(s >> 16); m_acc3 = s & 32'hFFFF;
        m_y1 = c1;
        m_y2 = c1 + c2 - m_c2z1;
        m_y3 = m_y2 + c3 - 2 * m_c3z1 + m_c3z2;
        m_c3z2 = m_c3z1; m_c3z1 = c3; m_c2z1 = c2;
        m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
        if (m_cnt < 3) m_cnt++;
      end
      if (load) m_frac = frac_in;
    end
  endtask

  function automatic logic [14:0] model_vec();
    return {4'(m_y1), 4'(m_y2), 4'(m_y3),
            1'(m_cnt >= 1), 1'(m_cnt >= 2), 1'(m_cnt >= 3)};
  endfunction

  // Drive one cycle, step the model on the edge, sample 1 ns later.
  task automatic tick(input logic e, input logic l, input logic [15:0] f, input logic d);
    en = e; load = l; frac_in = f; dither_en = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Reset with junk on en/load/frac_in/dither_en: rst must override them all.
  task automatic do_reset();
    rst = 1'b1;
    tick(1'b1, 1'b1, 16'hFFFF, 1'b1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({y1, y2, y3} !== 12'h000) begin
      errors++; $display("FAIL reset_y got %h required 000", {y1, y2, y3});
    end
    checks++;
    if ({v1, v2, v3} !== 3'b000) begin
      errors++; $display("FAIL reset_valid got %b required 000", {v1, v2, v3});
    end
  endtask

  // frac_q must be 0 after reset (load was high during rst), so y stays 0.
  task automatic test_prime();
    logic [2:0] pv [4] = '{3'b100, 3'b110, 3'b111, 3'b111};
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b0, 16'h0, 1'b0);
      checks++;
      if ({v1, v2, v3} !== pv[k]) begin
        errors++; $display("FAIL prime_valid step %0d got %b required %b", k, {v1, v2, v3}, pv[k]);
      end
      checks++;
      if ({y1, y2, y3} !== 12'h000) begin
        errors++; $display("FAIL prime_y step %0d got %h required 000", k, {y1, y2, y3});
      end
    end
    // en low: valid holds
    tick(1'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if ({v1, v2, v3} !== 3'b111) begin
      errors++; $display("FAIL prime_hold got %b required 111", {v1, v2, v3});
    end
  endtask

  task automatic test_order1_half();
    do_reset();
    tick(1'b0, 1'b1, 16'h8000, 1'b0);
    checks++;
    if (v1 !== 1'b0) begin
      errors++; $display("FAIL half_valid_pre got %b required 0", v1);
    end
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 1'b0, 16'h0, 1'b0);
      checks++;
      if (y1 !== 4'(k % 2) || v1 !== 1'b1) begin
        errors++; $display("FAIL half_y1 step %0d got y=%0d v=%b required y=%0d v=1", k, y1, v1, k % 2);
      end
    end
  endtask

  task automatic test_zero_frac();
    int nz = 0;
    do_reset();
    for (int k = 0; k < 32; k++) begin
      tick(1'b1, 1'b0, 16'h0, 1'b0);
      if ({y1, y2, y3} !== 12'h000) nz++;
    end
    checks++;
    if (nz != 0) begin
      errors++; $display("FAIL zero_frac nonzero samples got %0d required 0", nz);
    end
  endtask

  task automatic test_quarter();
    int sum1 = 0, sum2 = 0, sum3 = 0, bad = 0;
    do_reset();
    tick(1'b0, 1'b1, 16'h4000, 1'b0);
    for (int k = 0; k < 4096; k++) begin
      tick(1'b1, 1'b0, 16'h0, 1'b0);
      sum1 += int'(y1); sum2 += int'(y2); sum3 += int'(y3);
      if (y3 < -3 || y3 > 4) bad++;
    end
    checks++;
    if (sum3 != 1024) begin
      errors++; $display("FAIL quarter_sum3 got %0d required 1024", sum3);
    end
    checks++;
    if (sum2 != 1024 || sum1 != 1024) begin
      errors++; $display("FAIL quarter_sum12 got %0d/%0d required 1024/1024", sum1, sum2);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL quarter_range out-of-range samples got %0d required 0", bad);
    end
  endtask

  task automatic test_dither_zero();
    int sum3 = 0, bad = 0, mm = 0;
    do_reset();
    for (int k = 0; k < 65536; k++) begin
      tick(1'b1, 1'b0, 16'h0, 1'b1);
      sum3 += int'(y3);
      if (y3 < -3 || y3 > 4) bad++;
      if ({y1, y2, y3, v1, v2, v3} !== model_vec()) mm++;
    end
    checks++;
    if (mm != 0) begin
      errors++; $display("FAIL dither_model mismatching samples got %0d required 0", mm);
    end
    checks++;
    if (sum3 < -4 || sum3 > 4) begin
      errors++; $display("FAIL dither_mean sum got %0d required within -4..4", sum3);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL dither_range out-of-range samples got %0d required 0", bad);
    end
  endtask

  task automatic test_en_throttle();
    do_reset();
    tick(1'b0, 1'b1, 16'h5A5F, 1'b1);
    for (int k = 0; k < 90; k++) begin
      tick(1'((k % 3) == 0), 1'b0, 16'h0, 1'b1);
      checks++;
      if ({y1, y2, y3, v1, v2, v3} !== model_vec()) begin
        errors++;
        if (errors < 20)
          $display("FAIL throttle step %0d got %h required %h", k, {y1, y2, y3, v1, v2, v3}, model_vec());
      end
    end
  endtask

  task automatic test_load_concurrent();
    logic [3:0] ex [6] = '{4'd1, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0};
    do_reset();
    tick(1'b0, 1'b1, 16'h8000, 1'b0);
    tick(1'b1, 1'b0, 16'h0, 1'b0);
    checks++;
    if (y1 !== 4'd0) begin
      errors++; $display("FAIL loadc_first got %0d required 0", y1);
    end
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'(k == 0), 16'hC000, 1'b0);
      checks++;
      if (y1 !== ex[k]) begin
        errors++; $display("FAIL loadc_y1 step %0d got %0d required %0d", k, y1, ex[k]);
      end
      checks++;
      if ({y1, y2, y3, v1, v2, v3} !== model_vec()) begin
        errors++; $display("FAIL loadc_model step %0d got %h required %h", k, {y1, y2, y3, v1, v2, v3}, model_vec());
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [14:0] ref_seq [25];
    do_reset();
    tick(1'b0, 1'b1, 16'h3333, 1'b1);
    for (int k = 0; k < 25; k++) begin
      tick(1'b1, 1'b0, 16'h0, 1'b1);
      ref_seq[k] = model_vec();
      checks++;
      if ({y1, y2, y3, v1, v2, v3} !== ref_seq[k]) begin
        errors++; $display("FAIL rstmid_first step %0d got %h required %h", k, {y1, y2, y3, v1, v2, v3}, ref_seq[k]);
      end
    end
    do_reset();
    checks++;
    if ({y1, y2, y3, v1, v2, v3} !== 15'h0) begin
      errors++; $display("FAIL rstmid_clear got %h required 0000", {y1, y2, y3, v1, v2, v3});
    end
    tick(1'b0, 1'b1, 16'h3333, 1'b1);
    for (int k = 0; k < 25; k++) begin
      tick(1'b1, 1'b0, 16'h0, 1'b1);
      checks++;
      if ({y1, y2, y3, v1, v2, v3} !== ref_seq[k]) begin
        errors++; $display("FAIL rstmid_replay step %0d got %h required %h", k, {y1, y2, y3, v1, v2, v3}, ref_seq[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_prime();
    test_order1_half();
    test_zero_frac();
    test_quarter();
    test_load_concurrent();
    test_en_throttle();
    test_rst_mid();
    test_dither_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
